// File: rtl/toggle_decoder.sv
// rtl/toggle_decoder.sv - toggle-line event decoder: synchronizer, glitch filter, pending counter
// Optional glitch rejection counter enabled by TOGGLE_DECODER_GLITCH_CNT_EN.
module toggle_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             z_in,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic             level
`ifdef TOGGLE_DECODER_GLITCH_CNT_EN
  ,
  output logic [7:0]       glitch_cnt
`endif
);

  localparam int FW = $clog2(FILT_LEN + 1);

  typedef enum logic {ST_STABLE, ST_QUAL} state_t;

  state_t                 state, state_nx;
  logic [FW-1:0]          cnt, cnt_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   accept;
  logic                   reject;
  logic                   pop;
  logic                   ovf_set;
  logic [CNT_W-1:0]       pending_nx;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (clr) begin
      sync_q <= '0;
      state  <= ST_STABLE;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], z_in};
      state  <= state_nx;
      cnt    <= cnt_nx;
      if (accept) level <= ~level;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    reject   = 1'b0;
    case (state)
      ST_STABLE: begin
        if (sync_out != level) begin
          if (FILT_LEN == 1) begin
            accept = 1'b1;
          end else begin
            state_nx = ST_QUAL;
            cnt_nx   = FW'(1);
          end
        end
      end
      ST_QUAL: begin
        if (sync_out == level) begin
          reject   = 1'b1;
          state_nx = ST_STABLE;
          cnt_nx   = '0;
        end else if (cnt == FW'(FILT_LEN - 1)) begin
          accept   = 1'b1;
          state_nx = ST_STABLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + FW'(1);
        end
      end
      default: begin
        state_nx = ST_STABLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // ev_valid depends only on the pending register, never on ev_ready
  assign ev_valid = (pending != '0);
  assign pop      = ev_valid && ev_ready;

  always_comb begin
    pending_nx = pending;
    ovf_set    = 1'b0;
    case ({accept, pop})
      2'b10: begin
        if (pending == {CNT_W{1'b1}}) ovf_set = 1'b1;
        else pending_nx = pending + CNT_W'(1);
      end
      2'b01:   pending_nx = pending - CNT_W'(1);
      default: pending_nx = pending;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pending_nx;
      overflow <= (overflow && !clr_ovf) || ovf_set;
    end
  end

`ifdef TOGGLE_DECODER_GLITCH_CNT_EN
  always_ff @(posedge clk) begin
    if (clr) glitch_cnt <= 8'd0;
    else if (reject && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_toggle_decoder.sv
// tb/tb_toggle_decoder.sv - directed bench with pop scoreboard for toggle_decoder
module tb_toggle_decoder;

  logic       clk = 1'b0;
  logic       clr;
  logic       z_in;
  logic       ev_valid;
  logic       ev_ready;
  logic [3:0] pending;
  logic       overflow;
  logic       clr_ovf;
  logic       level;
`ifdef TOGGLE_DECODER_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  toggle_decoder #(.SYNC_STAGES(2), .FILT_LEN(4), .CNT_W(4)) dut (
    .clk      (clk),
    .clr      (clr),
    .z_in     (z_in),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .pending  (pending),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .level    (level)
`ifdef TOGGLE_DECODER_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    z_in     = 1'b0;
    ev_ready = 1'b0;
    clr_ovf  = 1'b0;
    clr      = 1'b1;
    step(2);
    clr = 1'b0;
  endtask

  // Scoreboard monitor: each handshake must match a queued expected pre-pop count
  always @(negedge clk) begin
    if (!clr && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pending %0d expected no pop", pending);
      end else begin
        check("pop_pending", int'(pending), exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset state and idle line
    do_reset();
    check("rst_level", level, 0);
    check("rst_pending", pending, 0);
    check("rst_valid", ev_valid, 0);
    check("rst_ovf", overflow, 0);
    step(20);
    check("idle_pending", pending, 0);

    // 2: single toggle latency, then pop
    z_in = 1'b1;
    step(5);
    check("lat_pending_e4", pending, 0);
    check("lat_level_e4", level, 0);
    step(1);
    check("lat_pending_e5", pending, 1);
    check("lat_level_e5", level, 1);
    check("lat_valid_e5", ev_valid, 1);
    ev_ready = 1'b1;
    exp_q.push_back(1);
    step(1);
    ev_ready = 1'b0;
    check("pop_pending_after", pending, 0);
    check("pop_valid_after", ev_valid, 0);

    // 3: short pulse rejected
    do_reset();
    z_in = 1'b1;
    step(2);
    z_in = 1'b0;
    step(10);
    check("glitch_level", level, 0);
    check("glitch_pending", pending, 0);
`ifdef TOGGLE_DECODER_GLITCH_CNT_EN
    check("glitch_cnt", glitch_cnt, 1);
`endif

    // 4: saturation and overflow
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      z_in = ~z_in;
      step(10);
      check($sformatf("sat_pending_%0d", i), pending, (i > 15) ? 15 : i);
      check($sformatf("sat_ovf_%0d", i), overflow, (i == 16) ? 1 : 0);
    end
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check("clr_ovf_ovf", overflow, 0);
    check("clr_ovf_pending", pending, 15);
    z_in = ~z_in;
    step(5);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check("ovf_set_wins", overflow, 1);
    check("ovf_set_pending", pending, 15);

    // 5: accept and pop on the same edge, then drain and underflow guard
    do_reset();
    for (int i = 0; i < 3; i++) begin
      z_in = ~z_in;
      step(10);
    end
    check("pre_simul_pending", pending, 3);
    z_in = ~z_in;
    step(5);
    ev_ready = 1'b1;
    exp_q.push_back(3);
    step(1);
    ev_ready = 1'b0;
    check("simul_pending", pending, 3);
    check("simul_level", level, 0);
    ev_ready = 1'b1;
    exp_q.push_back(3);
    exp_q.push_back(2);
    exp_q.push_back(1);
    step(3);
    ev_ready = 1'b0;
    check("drain_pending", pending, 0);
    check("drain_valid", ev_valid, 0);
    ev_ready = 1'b1;
    step(3);
    ev_ready = 1'b0;
    check("no_underflow", pending, 0);

    // 6: clr mid-qualification, line still high after release
    do_reset();
    z_in = 1'b1;
    step(3);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("midq_level", level, 0);
    check("midq_pending", pending, 0);
    step(5);
    check("midq_pending_e4", pending, 0);
    step(1);
    check("midq_pending_e5", pending, 1);
    check("midq_level_e5", level, 1);
    step(20);
    check("midq_single_event", pending, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/toggle_decoder.md
Name: toggle_decoder

Overview:
- Receive-side counterpart of the toggle-flop FSM. A remote block signals each event by inverting a level line (z1-style toggle output).
- This block synchronizes that line, filters glitches, and turns each accepted level change into one event.
- Events are queued in a saturating pending counter and popped by the consumer through a valid/ready handshake.
- Sits at the clock-domain/board boundary in front of any logic that consumes toggle-encoded events.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on z_in (legal >= 2)
FILT_LEN, 4, consecutive sampled cycles the synchronized line must differ from the accepted level before a toggle is accepted (legal >= 1)
CNT_W, 4, width of pending event counter; max pending = 2^CNT_W - 1

Ports:
clk  input  1  rising-edge clock
clr  input  1  reset, synchronous, active-high; clock is clk
z_in  input  1  asynchronous toggle line; each level change = one event
ev_valid  output  1  high while at least one event is pending
ev_ready  input  1  consumer pops one event when ev_valid && ev_ready at a rising edge
pending  output  CNT_W  number of undelivered events
overflow  output  1  sticky; an event was dropped because pending was at max
clr_ovf  input  1  clears overflow
level  output  1  current accepted (filtered) line level

Behaviour:
- Reset (clr=1 at rising edge): synchronizer flops=0, level=0, filter count=0, FSM=ST_STABLE, pending=0, overflow=0. ev_valid=0 follows. clr overrides every other input that cycle.
- Synchronizer: SYNC_STAGES flops in series; sync_out = last stage. No other logic reads z_in.
- Filter FSM:
  - ST_STABLE: if sync_out==level, stay. Otherwise, if FILT_LEN==1, accept now; else go to ST_QUAL with cnt=1.
  - ST_QUAL: if sync_out==level, go to ST_STABLE with cnt=0 (glitch rejected). Else if cnt==FILT_LEN-1: accept, go to ST_STABLE, cnt=0. Else cnt++.
  - Accept = level<=~level plus one accept strobe into the pending logic in the same cycle.
- Latency: z_in changes before edge 0 and is held. level and pending update at edge SYNC_STAGES+FILT_LEN-1 (edge 5 with defaults). ev_valid is high after that edge.
- Pulses shorter than FILT_LEN sampled cycles are rejected. Two toggles closer than that may cancel and produce no event; this is accepted behaviour.
- Pending counter, per edge:
  - accept only: +1, or hold at max and set overflow.
  - pop only: -1.
  - accept and pop together: unchanged, with no overflow even at max.
  - neither: hold.
- ev_valid = (pending != 0), driven from register state only; no combinational path from ev_ready.
- ev_ready while ev_valid=0 is ignored; pending never underflows.
- overflow: set on a dropped event, cleared by clr_ovf. A set and a clear in the same cycle leave overflow = 1.
- Line is idle-low after reset. If z_in is 1 when clr releases, exactly one event is decoded after normal latency.
- clr mid-qualification discards the partially qualified toggle and any pending events.

Optional Feature:
- Macro TOGGLE_DECODER_GLITCH_CNT_EN.
- Defined: adds output glitch_cnt (8 bits). It increments on each ST_QUAL->ST_STABLE rejection, saturates at 255, and clears on clr.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. clr=1 for 2 edges, z_in=0 -> level=0, pending=0, ev_valid=0, overflow=0. No event for the next 20 cycles.
2. z_in 0->1 and held, ev_ready=0 -> pending=1, level=1 and ev_valid=1 after edge 5, not before. Then ev_ready=1 for one edge -> pending=0, ev_valid=0.
3. z_in high for 2 cycles, then low -> level stays 0, pending stays 0. With the macro defined, glitch_cnt=1.
4. CNT_W=4, ev_ready=0, 16 toggles spaced 10 cycles apart -> pending saturates at 15 and overflow=1 after the 16th accept. Then clr_ovf=1 for one edge -> overflow=0, pending stays 15.
5. pending=3, ev_ready=1 held, and a toggle accepted on the same edge as a pop -> pending stays 3 on that edge.
6. Toggle z_in to 1, then clr=1 at edge 3 for one edge -> all state reset, level=0, no event. Because z_in is still 1, exactly one event is accepted 5 edges after clr releases.
